// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register: DEPTH-entry circular skid buffer with valid/ready and sync flush.
// One-cycle latency; in_ready comes from registered occupancy only, so a full buffer refills a cycle after draining.
module pipe_stage_buf #(
  parameter int              WIDTH            = 32,
  parameter int              DEPTH            = 2,
  parameter logic [WIDTH-1:0] BUBBLE_DATA     = '0,
  parameter bit              FLUSH_KEEPS_HEAD = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : BUBBLE_DATA;
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // An empty buffer must have rd == wr so the next push lands at the head.
      if (FLUSH_KEEPS_HEAD && out_valid && !pop) begin
        count_d  = CW'(1);
        wr_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        count_d  = '0;
        rd_ptr_d = wr_ptr_q;
      end
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: four instances cover DEPTH 1/2/3 and keep-head flush.
module tb_pipe_stage_buf;

  localparam logic [31:0] NOOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u2: DEPTH 2
  logic v2 = 0, r2 = 0, f2 = 0, ir2, ov2;
  logic [31:0] d2 = '0, od2;
  logic [1:0] c2;
  // u3: DEPTH 3
  logic v3 = 0, r3 = 0, f3 = 0, ir3, ov3;
  logic [31:0] d3 = '0, od3;
  logic [1:0] c3;
  // u1: DEPTH 1
  logic v1 = 0, r1 = 0, f1 = 0, ir1, ov1;
  logic [31:0] d1 = '0, od1;
  logic [0:0] c1;
  // uk: DEPTH 3, flush keeps head
  logic vk = 0, rk = 0, fk = 0, irk, ovk;
  logic [31:0] dk = '0, odk;
  logic [1:0] ck;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .BUBBLE_DATA(NOOP), .FLUSH_KEEPS_HEAD(1'b0)) u2 (
    .clk(clk), .rst(rst), .flush(f2), .in_valid(v2), .in_data(d2), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_ready(r2), .count(c2));
  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .BUBBLE_DATA(NOOP), .FLUSH_KEEPS_HEAD(1'b0)) u3 (
    .clk(clk), .rst(rst), .flush(f3), .in_valid(v3), .in_data(d3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_ready(r3), .count(c3));
  pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .BUBBLE_DATA(NOOP), .FLUSH_KEEPS_HEAD(1'b0)) u1 (
    .clk(clk), .rst(rst), .flush(f1), .in_valid(v1), .in_data(d1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(r1), .count(c1));
  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .BUBBLE_DATA(NOOP), .FLUSH_KEEPS_HEAD(1'b1)) uk (
    .clk(clk), .rst(rst), .flush(fk), .in_valid(vk), .in_data(dk), .in_ready(irk),
    .out_valid(ovk), .out_data(odk), .out_ready(rk), .count(ck));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] base;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_u2_valid", 32'(ov2), 0);
    chk("rst_u2_data", od2, NOOP);
    chk("rst_u2_ready", 32'(ir2), 1);
    chk("rst_u2_count", 32'(c2), 0);
    chk("rst_u3_data", od3, NOOP);
    chk("rst_u1_ready", 32'(ir1), 1);
    chk("rst_uk_count", 32'(ck), 0);

    // Streaming through DEPTH 2
    r2 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      v2 = 1'b1; d2 = 32'(i);
      tick();
      chk("stream_valid", 32'(ov2), 1);
      chk("stream_data", od2, 32'(i));
      chk("stream_count", 32'(c2), 1);
      chk("stream_ready", 32'(ir2), 1);
    end
    v2 = 1'b0;
    tick();
    chk("stream_drain_valid", 32'(ov2), 0);
    chk("stream_drain_data", od2, NOOP);

    // Back-pressure and pointer wrap at DEPTH 3
    for (int rnd = 0; rnd < 5; rnd++) begin
      base = 32'hA000_0000 + 32'(rnd * 16);
      r3 = 1'b0;
      for (int k = 0; k < 3; k++) begin
        v3 = 1'b1; d3 = base + 32'(k);
        tick();
        chk("bp_fill_count", 32'(c3), 32'(k + 1));
        chk("bp_fill_head", od3, base);
      end
      chk("bp_full_ready", 32'(ir3), 0);
      d3 = base + 32'd3;
      tick();
      chk("bp_held_count", 32'(c3), 3);
      chk("bp_held_ready", 32'(ir3), 0);
      r3 = 1'b1;
      tick();
      chk("bp_pop_a_count", 32'(c3), 2);
      chk("bp_out_b", od3, base + 32'd1);
      chk("bp_ready_back", 32'(ir3), 1);
      tick();
      v3 = 1'b0;
      chk("bp_out_c", od3, base + 32'd2);
      chk("bp_d_taken_count", 32'(c3), 2);
      tick();
      chk("bp_out_d", od3, base + 32'd3);
      chk("bp_last_count", 32'(c3), 1);
      tick();
      chk("bp_empty_valid", 32'(ov3), 0);
      chk("bp_empty_data", od3, NOOP);
    end

    // Flush drops everything, including the same-cycle push
    r3 = 1'b0;
    v3 = 1'b1; d3 = 32'hA; tick();
    d3 = 32'hB; tick();
    chk("fl_pre_count", 32'(c3), 2);
    d3 = 32'hC; f3 = 1'b1;
    tick();
    f3 = 1'b0; v3 = 1'b0;
    chk("fl_count", 32'(c3), 0);
    chk("fl_valid", 32'(ov3), 0);
    chk("fl_ready", 32'(ir3), 1);
    chk("fl_data", od3, NOOP);
    r3 = 1'b1;
    tick();
    chk("fl_no_c", 32'(ov3), 0);
    v3 = 1'b1; d3 = 32'hE;
    tick();
    v3 = 1'b0;
    chk("fl_after_e", od3, 32'hE);
    tick();
    chk("fl_after_empty", 32'(c3), 0);

    // Flush keeping the head entry
    vk = 1'b1; dk = 32'hA; tick();
    dk = 32'hB; tick();
    dk = 32'hC; fk = 1'b1;
    tick();
    fk = 1'b0;
    chk("kh_count", 32'(ck), 1);
    chk("kh_valid", 32'(ovk), 1);
    chk("kh_head", odk, 32'hA);
    dk = 32'hE;
    tick();
    vk = 1'b0;
    chk("kh_push_count", 32'(ck), 2);
    rk = 1'b1;
    tick();
    chk("kh_e_after_a", odk, 32'hE);
    chk("kh_e_count", 32'(ck), 1);
    tick();
    chk("kh_empty", 32'(ovk), 0);
    rk = 1'b0; vk = 1'b1; dk = 32'h55;
    tick();
    vk = 1'b0; rk = 1'b1; fk = 1'b1;
    tick();
    fk = 1'b0;
    chk("kh_pop_flush_count", 32'(ck), 0);
    chk("kh_pop_flush_data", odk, NOOP);

    // DEPTH 1: full buffer refuses a push even while popping
    v1 = 1'b1; d1 = 32'hA;
    tick();
    chk("d1_full_count", 32'(c1), 1);
    chk("d1_full_ready", 32'(ir1), 0);
    chk("d1_head", od1, 32'hA);
    d1 = 32'hB; r1 = 1'b1;
    tick();
    chk("d1_pop_count", 32'(c1), 0);
    chk("d1_pop_valid", 32'(ov1), 0);
    chk("d1_pop_ready", 32'(ir1), 1);
    tick();
    v1 = 1'b0;
    chk("d1_b_accepted", od1, 32'hB);
    chk("d1_b_count", 32'(c1), 1);
    tick();
    chk("d1_drained", 32'(c1), 0);

    // Reset mid-stream
    r2 = 1'b0;
    v2 = 1'b1; d2 = 32'h111; tick();
    d2 = 32'h222; tick();
    v2 = 1'b0;
    chk("mr_pre_count", 32'(c2), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_count", 32'(c2), 0);
    chk("mr_valid", 32'(ov2), 0);
    chk("mr_data", od2, NOOP);
    chk("mr_ready", 32'(ir2), 1);
    r2 = 1'b1;
    tick();
    chk("mr_no_stale_valid", 32'(ov2), 0);
    tick();
    chk("mr_no_stale_data", od2, NOOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
